muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have port i_clk input 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port i_rst input 1: reset, synchronous and active-high.
REQ-004 SHALL have port i_start input 1: request a MULT/DIV operation.
REQ-005 SHALL have port i_op input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports i_src1 and i_src2 input WIDTH: multiplicand/dividend and multiplier/divisor.
REQ-007 SHALL have ports i_mthi and i_mtlo input 1: direct write strobes for HI and LO.
REQ-008 SHALL have port i_wdata input WIDTH: data for i_mthi/i_mtlo.
REQ-009 SHALL have port o_busy output 1: unit occupied, pipeline must stall MFHI/MFLO and further MULT/DIV.
REQ-010 SHALL have port o_done output 1: one-cycle pulse, HI/LO hold a fresh result.
REQ-011 SHALL have port o_div_by_zero output 1: qualifies o_done, divide had zero divisor.
REQ-012 SHALL have ports o_hi and o_lo output WIDTH: registered HI/LO contents.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX.
REQ-014 SHALL accept i_start only in IDLE; i_start in RUN/FIX is ignored with no side effect.
REQ-015 SHALL, on accept, latch operands and op, convert signed ops (MULT/DIV) to WIDTH-bit unsigned magnitudes, record result signs, and go to RUN.
REQ-016 SHALL, in RUN, perform one iteration per cycle (shift-add multiply, restoring divide) for exactly WIDTH cycles, then go to FIX.
REQ-017 SHALL, in FIX, apply sign correction and, on the FIX->IDLE edge, write HI/LO and set o_done for exactly one cycle.
REQ-018 SHALL give latency: i_start sampled at edge 0 -> o_busy high cycles 1..WIDTH+1, HI/LO updated and o_done high in cycle WIDTH+2 (34 for WIDTH=32), o_busy low in that cycle.
REQ-019 SHALL produce a 2*WIDTH-bit product for multiply: HI = upper half, LO = lower half; MULT signed, MULTU unsigned.
REQ-020 SHALL produce for divide LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign.
REQ-021 SHALL give DIV of the most-negative value by -1 LO = most-negative value, HI = 0, with no flag.
REQ-022 SHALL, for DIV/DIVU with i_src2 == 0, go IDLE->FIX directly, then write HI = i_src1 and LO = all ones, pulse o_done together with o_div_by_zero in cycle 2.
REQ-023 SHALL keep o_div_by_zero at 0 whenever o_done is 0.
REQ-024 SHALL, in IDLE, write i_wdata into HI on i_mthi and into LO on i_mtlo, both if both asserted; visible on o_hi/o_lo the next cycle.
REQ-025 SHALL ignore i_mthi/i_mtlo in RUN/FIX and in any IDLE cycle where i_start is accepted (start has priority).
REQ-026 SHALL hold o_hi/o_lo stable during RUN/FIX until the result write.
REQ-027 SHALL derive o_busy as (state != IDLE), registered state only, with no combinational path from inputs.

Reset
REQ-028 SHALL, with i_rst high at a clock edge, force state IDLE, o_hi = 0, o_lo = 0, o_busy = 0, o_done = 0, o_div_by_zero = 0.
REQ-029 SHALL, on reset mid-operation, abort the operation with no later o_done and no HI/LO write.
REQ-030 SHALL give reset priority over i_start, i_mthi and i_mtlo in the same cycle.

Verification
REQ-031 SHALL check: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_done at cycle 34, HI = 0xFFFFFFFE, LO = 0x00000001, o_busy high cycles 1..33.
REQ-032 SHALL check: MULT -3 x 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-033 SHALL check: DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0x00000000, o_div_by_zero = 0.
REQ-034 SHALL check: DIVU 0x0000000A / 0 -> o_done and o_div_by_zero high in cycle 2, HI = 0x0000000A, LO = 0xFFFFFFFF.
REQ-035 SHALL check: second i_start at cycle 5 and i_mthi at cycle 6 during an operation -> both ignored, a single o_done at cycle 34 with the first operation's result.
REQ-036 SHALL check: i_rst at cycle 10 of a DIVU -> cycle 11 all outputs 0, no o_done within 40 cycles, then i_mtlo 0x1234 in IDLE -> o_lo = 0x00001234 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring (divide) step per cycle on unsigned
// magnitudes; signs are recorded at start and reapplied in a single FIX cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] accHi_q;
  logic [WIDTH-1:0] accLo_q;
  logic [WIDTH-1:0] opB_q;
  logic             isDiv_q;
  logic             negQ_q;
  logic             negR_q;
  logic             divZero_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;

  logic             isDiv_d;
  logic             negA_d;
  logic             negB_d;
  logic [WIDTH-1:0] magA_d;
  logic [WIDTH-1:0] magB_d;
  logic [WIDTH-1:0] stepHi_d;
  logic [WIDTH-1:0] stepLo_d;
  logic [WIDTH-1:0] fixHi_d;
  logic [WIDTH-1:0] fixLo_d;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divSub;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodNeg;

  // Decode the requested op and form unsigned operand magnitudes at accept time
  always_comb begin
    isDiv_d = i_op[1];
    negA_d  = ~i_op[0] & i_src1[WIDTH-1];
    negB_d  = ~i_op[0] & i_src2[WIDTH-1];
    magA_d  = negA_d ? -i_src1 : i_src1;
    magB_d  = negB_d ? -i_src2 : i_src2;
  end

  // One iteration: multiply adds the multiplicand into HI when LO's LSB is set
  // and shifts the pair right; divide shifts the dividend bit into the remainder
  // and subtracts the divisor when it fits, shifting the quotient bit into LO
  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : {(WIDTH+1){1'b0}});
    divShift = {accHi_q, accLo_q[WIDTH-1]};
    divSub   = divShift[WIDTH-1:0] - opB_q;
    stepHi_d = accHi_q;
    stepLo_d = accLo_q;
    if (isDiv_q) begin
      if (divShift >= {1'b0, opB_q}) begin
        stepHi_d = divSub;
        stepLo_d = {accLo_q[WIDTH-2:0], 1'b1};
      end else begin
        stepHi_d = divShift[WIDTH-1:0];
        stepLo_d = {accLo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      stepHi_d = mulSum[WIDTH:1];
      stepLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied on the way out; divide-by-zero results pass through
  // untouched because they were preloaded with the architectural fallback values
  always_comb begin
    prod    = {accHi_q, accLo_q};
    prodNeg = -prod;
    fixHi_d = accHi_q;
    fixLo_d = accLo_q;
    if (!divZero_q) begin
      if (isDiv_q) begin
        fixLo_d = negQ_q ? -accLo_q : accLo_q;
        fixHi_d = negR_q ? -accHi_q : accHi_q;
      end else if (negQ_q) begin
        fixHi_d = prodNeg[2*WIDTH-1:WIDTH];
        fixLo_d = prodNeg[WIDTH-1:0];
      end
    end
  end

  // Control FSM plus datapath and HI/LO registers; done/flag are one-cycle pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      opB_q     <= '0;
      isDiv_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            isDiv_q <= isDiv_d;
            negQ_q  <= negA_d ^ negB_d;
            negR_q  <= negA_d;
            cnt_q   <= '0;
            if (isDiv_d && (i_src2 == '0)) begin
              divZero_q <= 1'b1;
              accHi_q   <= i_src1;
              accLo_q   <= '1;
              opB_q     <= '0;
              state_q   <= FIX;
            end else begin
              divZero_q <= 1'b0;
              accHi_q   <= '0;
              accLo_q   <= isDiv_d ? magA_d : magB_d;
              opB_q     <= isDiv_d ? magB_d : magA_d;
              state_q   <= RUN;
            end
          end else begin
            if (i_mthi) hi_q <= i_wdata;
            if (i_mtlo) lo_q <= i_wdata;
          end
        end
        RUN: begin
          accHi_q <= stepHi_d;
          accLo_q <= stepLo_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fixHi_d;
          lo_q    <= fixLo_d;
          done_q  <= 1'b1;
          dbz_q   <= divZero_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;
  assign o_div_by_zero = dbz_q;
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a vector table of ops with hand-computed
// HI/LO/latency, plus hand-written sequences for stall, reset and MTHI/MTLO.
module tb_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
    logic         expDbz;
    int           expCycle;
  } vec_t;

  vec_t vecs[$];

  muldiv_ctrl #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_op          (op),
    .i_src1        (src1),
    .i_src2        (src2),
    .i_mthi        (mthi),
    .i_mtlo        (mtlo),
    .i_wdata       (wdata),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Launch one op (sampled at "edge 0") and watch cycles 1..45 at negedges
  task automatic applyStimulus(input logic [1:0] vOp, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int expCycle, output int doneCycle,
                               output logic [W-1:0] rHi, output logic [W-1:0] rLo,
                               output logic rDbz, output int protoErrs);
    logic [W-1:0] hiBefore;
    logic [W-1:0] loBefore;
    hiBefore  = hi;
    loBefore  = lo;
    doneCycle = -1;
    protoErrs = 0;
    rHi = '0; rLo = '0; rDbz = 1'b0;
    start = 1'b1; op = vOp; src1 = a; src2 = b;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (busy !== (c < expCycle)) protoErrs++;
      if (done !== 1'b1 && dbz !== 1'b0) protoErrs++;
      if (c < expCycle && (hi !== hiBefore || lo !== loBefore)) protoErrs++;
      if (done === 1'b1) begin
        if (doneCycle < 0) begin
          doneCycle = c; rHi = hi; rLo = lo; rDbz = dbz;
        end else begin
          protoErrs++;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int           dc;
    int           pe;
    int           doneCount;
    logic [W-1:0] rh;
    logic [W-1:0] rl;
    logic         rd;

    rst = 1'b1; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;

    // MULTU/MULT/DIV/DIVU table with hand-computed results
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34});
    vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34});
    vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34});
    vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34});
    vecs.push_back('{2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1, 2});
    vecs.push_back('{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34});
    vecs.push_back('{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34});
    vecs.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34});
    vecs.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34});
    vecs.push_back('{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2});
    vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34});
    vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34});

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset hi", hi, '0);
    checkOutput("reset lo", lo, '0);
    checkOutput("reset busy", {31'b0, busy}, '0);
    checkOutput("reset done", {31'b0, done}, '0);
    checkOutput("reset dbz", {31'b0, dbz}, '0);

    // MTHI/MTLO in IDLE, individually and together
    mthi = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthi hi", hi, 32'hAAAA5555);
    checkOutput("mthi lo untouched", lo, '0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checkOutput("mthi+mtlo hi", hi, 32'h0BADF00D);
    checkOutput("mthi+mtlo lo", lo, 32'h0BADF00D);

    // Table-driven operations
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expCycle, dc, rh, rl, rd, pe);
      checkInt($sformatf("v%0d done cycle", i), dc, vecs[i].expCycle);
      checkOutput($sformatf("v%0d hi", i), rh, vecs[i].expHi);
      checkOutput($sformatf("v%0d lo", i), rl, vecs[i].expLo);
      checkOutput($sformatf("v%0d dbz", i), {31'b0, rd}, {31'b0, vecs[i].expDbz});
      checkInt($sformatf("v%0d busy/hold/pulse errors", i), pe, 0);
    end

    // Start has priority over MTLO in the accept cycle; HI/LO hold during the op
    mtlo = 1'b1; wdata = 32'hDEADBEEF;
    start = 1'b1; op = 2'b01; src1 = 32'd6; src2 = 32'd7;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    checkOutput("start beats mtlo", lo, 32'h0FFFFFFF);
    checkOutput("busy after start", {31'b0, busy}, 32'd1);
    while (busy === 1'b1) @(negedge clk);
    checkOutput("mulu 6x7 lo", lo, 32'd42);
    checkOutput("mulu 6x7 hi", hi, 32'd0);
    @(negedge clk);

    // Second start at cycle 5 and MTHI at cycle 6 are ignored
    doneCount = 0; dc = -1; rh = '0; rl = '0;
    start = 1'b1; op = 2'b01; src1 = 32'd3; src2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      start = (c == 5);
      op = 2'b11; src1 = 32'd99; src2 = 32'd9;
      mthi = (c == 6); wdata = 32'h55555555;
      if (done === 1'b1) begin
        doneCount++;
        if (dc < 0) begin dc = c; rh = hi; rl = lo; end
      end
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0;
    checkInt("ignored start: done count", doneCount, 1);
    checkInt("ignored start: done cycle", dc, 34);
    checkOutput("ignored start: lo", rl, 32'd12);
    checkOutput("ignored start: hi", rh, 32'd0);

    // Reset during a DIVU aborts it; then MTLO in IDLE
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77777777;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    start = 1'b1; op = 2'b11; src1 = 32'd1000; src2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst = 1'b1; start = 1'b1; mthi = 1'b1; wdata = 32'h99999999;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; mthi = 1'b0;
    checkOutput("abort hi", hi, '0);
    checkOutput("abort lo", lo, '0);
    checkOutput("abort busy", {31'b0, busy}, '0);
    checkOutput("abort done", {31'b0, done}, '0);
    checkOutput("abort dbz", {31'b0, dbz}, '0);
    doneCount = 0; pe = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0) doneCount++;
      if (busy !== 1'b0 || hi !== '0 || lo !== '0) pe++;
      @(negedge clk);
    end
    checkInt("abort: no later done", doneCount, 0);
    checkInt("abort: idle and zero", pe, 0);
    mtlo = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mtlo after abort", lo, 32'h00001234);
    checkOutput("hi after mtlo", hi, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
